// File: rtl/serial_subtractor_16bit.sv
// serial_subtractor_16bit: bit-serial a - b - bin, one result bit per cycle LSB first, with valid/ready handshakes
module serial_subtractor_16bit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero,
   output logic             out_valid,
   input  logic             out_ready
);
   localparam int IW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_next;
   logic [WIDTH-1:0] a_r, b_r, acc, result;
   logic [IW-1:0] idx;
   logic br, d, br_n, last;
   // full-subtractor cell for the current bit and the assembled result word
   always_comb begin
      d = a_r[idx] ^ b_r[idx] ^ br;
      br_n = (~a_r[idx] & b_r[idx]) | (~(a_r[idx] ^ b_r[idx]) & br);
      last = idx == IW'(WIDTH - 1);
      result = {d, acc[WIDTH-1:1]};
      in_ready = state == IDLE;
   end
   // next-state decode: accept in IDLE, finish after the MSB, release on consumer handshake
   always_comb begin
      state_next = state;
      if (state == IDLE && in_valid)
         state_next = RUN;
      else if (state == RUN && last)
         state_next = DONE;
      else if (state == DONE && out_ready)
         state_next = IDLE;
   end
   // state register and registered out_valid, both following the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         out_valid <= 1'b0;
      end else begin
         state <= state_next;
         out_valid <= state_next == DONE;
      end
   end
   // operand capture, serial datapath, and result/flag update on the final bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r <= '0;
         b_r <= '0;
         acc <= '0;
         idx <= '0;
         br <= 1'b0;
         diff <= '0;
         bout <= 1'b0;
         ovf <= 1'b0;
         zero <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         a_r <= a;
         b_r <= b;
         br <= bin;
         idx <= '0;
      end else if (state == RUN) begin
         acc <= result;
         br <= br_n;
         idx <= idx + IW'(1);
         if (last) begin
            diff <= result;
            bout <= br_n;
            ovf <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (d ^ a_r[WIDTH-1]);
            zero <= ~|result;
         end
      end
   end
endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// tb_serial_subtractor_16bit: directed and random checks of the serial subtractor against an arithmetic model
module tb_serial_subtractor_16bit;
   logic clk = 1'b0, rst = 1'b1;
   logic [15:0] a = '0, b = '0, diff;
   logic bin = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic in_ready, bout, ovf, zero, out_valid;
   int checks = 0, failures = 0;
   logic [18:0] q[$];

   serial_subtractor_16bit dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .bin(bin), .in_valid(in_valid),
      .in_ready(in_ready), .diff(diff), .bout(bout), .ovf(ovf), .zero(zero),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
      logic [16:0] f;
      logic o;
      f = {1'b0, x} - {1'b0, y} - {16'b0, c};
      o = (x[15] != y[15]) && (f[15] != x[15]);
      return {f[15:0], f[16], o, f[15:0] == 16'h0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_result(input string tag, input logic [18:0] e);
      chk({tag, "_diff"}, 32'(diff), 32'(e[18:3]));
      chk({tag, "_bout"}, 32'(bout), 32'(e[2]));
      chk({tag, "_ovf"}, 32'(ovf), 32'(e[1]));
      chk({tag, "_zero"}, 32'(zero), 32'(e[0]));
   endtask

   task automatic do_op(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c, input int stall);
      int cnt;
      logic [18:0] e;
      chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
      a = x;
      b = y;
      bin = c;
      in_valid = 1'b1;
      tick();
      q.push_back(model(x, y, c));
      in_valid = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      bin = 1'($urandom);
      cnt = 0;
      while (!out_valid && cnt < 40) begin
         tick();
         cnt++;
      end
      chk({tag, "_latency"}, 32'(cnt), 32'd16);
      e = q.pop_front();
      check_result(tag, e);
      out_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         a = 16'($urandom);
         b = 16'($urandom);
         tick();
         chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
         check_result({tag, "_stall"}, e);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_release_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_release_valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int first, second;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      check_result("rst", 19'h0);
      tick();
      tick();
      rst = 1'b0;
      do_op("sub_5_3", 16'h0005, 16'h0003, 1'b0, 0);
      do_op("wrap_0_1", 16'h0000, 16'h0001, 1'b0, 1);
      do_op("ovf_8000_1", 16'h8000, 16'h0001, 1'b0, 0);
      do_op("zero_bin", 16'h1234, 16'h1233, 1'b1, 0);
      do_op("edge_0_ffff_1", 16'h0000, 16'hFFFF, 1'b1, 0);
      do_op("edge_eq_bin", 16'h5A5A, 16'h5A5A, 1'b1, 0);
      do_op("stall5", 16'h7FFF, 16'hFFFF, 1'b0, 5);
      a = 16'h4321;
      b = 16'h1111;
      bin = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      rst = 1'b1;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_diff", 32'(diff), 32'd0);
      tick();
      rst = 1'b0;
      do_op("after_abort", 16'hFFFF, 16'h0001, 1'b0, 0);
      a = 16'h0009;
      b = 16'h0004;
      bin = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      first = 0;
      second = 0;
      for (int k = 1; k <= 45 && second == 0; k++) begin
         tick();
         if (in_ready) begin
            if (first == 0) first = k;
            else begin
               second = k;
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("tput_first_idle", 32'(first), 32'd18);
      chk("tput_period", 32'(second - first), 32'd18);
      chk("tput_diff", 32'(diff), 32'h0005);
      for (int n = 0; n < 1000; n++)
         do_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
